// File: rtl/mirror_monitor_pkg.sv
// Shared types and sizing helpers for the fan-out mirror checker.
package mirror_monitor_pkg;

  localparam int unsigned DEF_W      = 14;
  localparam int unsigned DEF_SETTLE = 2;
  localparam int unsigned DEF_CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, REPORT} mm_state_t;

  // Width of a down-counter that must hold SETTLE-1; never narrower than 1 bit.
  function automatic int unsigned settle_w(input int unsigned s);
    return (s < 2) ? 1 : $clog2(s + 1);
  endfunction

  localparam int unsigned SETTLE_W = settle_w(DEF_SETTLE);

endpackage

// File: rtl/mm_if.sv
// Fan-out observation bus plus mismatch-report handshake of the mirror checker.
interface mm_if
  import mirror_monitor_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             src;
  logic [W-1:0]     copies;
  logic             start;
  logic             busy;
  logic             err_valid;
  logic             err_ready;
  logic [W-1:0]     err_mask;
  logic [CNT_W-1:0] err_cnt;
  logic             done;

  modport master (
    output src, copies, start, err_ready,
    input  busy, err_valid, err_mask, err_cnt, done
  );

  modport slave (
    input  src, copies, start, err_ready,
    output busy, err_valid, err_mask, err_cnt, done
  );
endinterface

// File: rtl/mm_compare.sv
// 4-state per-copy mismatch mask; an unknown snapshot fails every copy.
module mm_compare #(
  parameter int unsigned W = 14
) (
  input  logic         snap_i,
  input  logic [W-1:0] copies_i,
  output logic [W-1:0] mismatch_c_o
);
  logic snap_known;

  always_comb begin
    snap_known = (snap_i === 1'b0) || (snap_i === 1'b1);
    for (int i = 0; i < int'(W); i++) begin
      mismatch_c_o[i] = (copies_i[i] !== snap_i) || !snap_known;
    end
  end
endmodule

// File: rtl/mirror_monitor.sv
// Snapshots src on start, waits SETTLE cycles, checks all copies and reports
// mismatches through a valid/ready handshake with a saturating report counter.
module mirror_monitor
  import mirror_monitor_pkg::*;
#(
  parameter int unsigned W      = DEF_W,
  parameter int unsigned SETTLE = DEF_SETTLE,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input logic  clk,
  input logic  rst,
  mm_if.slave  bus
);
  localparam int unsigned SW = settle_w(SETTLE);

  mm_state_t        state_q, state_d;
  logic             snap_q, snap_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             err_valid_q, err_valid_d;
  logic [W-1:0]     err_mask_q, err_mask_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             done_q, done_d;
  logic [W-1:0]     mismatch_c;

  mm_compare #(.W(W)) u_compare (
    .snap_i       (snap_q),
    .copies_i     (bus.copies),
    .mismatch_c_o (mismatch_c)
  );

  // Next-state and register updates; the parameter SETTLE shadows the enum
  // member, so that state is always named through the package.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    err_valid_d = err_valid_q;
    err_mask_d  = err_mask_q;
    err_cnt_d   = err_cnt_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start === 1'b1) begin
          snap_d  = bus.src;
          cnt_d   = SW'(SETTLE - 1);
          busy_d  = 1'b1;
          state_d = mirror_monitor_pkg::SETTLE;
        end
      end
      mirror_monitor_pkg::SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end
      CHECK: begin
        if (mismatch_c == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          err_mask_d  = mismatch_c;
          err_valid_d = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        if (err_valid_q && (bus.err_ready === 1'b1)) begin
          err_valid_d = 1'b0;
          err_mask_d  = '0;
          if (err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      snap_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_mask_q  <= '0;
      err_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      err_valid_q <= err_valid_d;
      err_mask_q  <= err_mask_d;
      err_cnt_q   <= err_cnt_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_mask  = err_mask_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mirror_monitor.sv
// Scoreboard bench: two checkers (8-bit and 2-bit report counters) share one
// stimulus stream; expectations come from a transaction-level model.
module tb_mirror_monitor;
  import mirror_monitor_pkg::*;

  localparam int unsigned W      = 14;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned CW_A   = 8;
  localparam int unsigned CW_B   = 2;

  typedef struct {
    logic [W-1:0] mask;
    int unsigned  start_cyc;
    int unsigned  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb_q[$];
  int unsigned n_reports = 0;
  bit          seen_valid = 1'b0;

  mm_if #(.W(W), .CNT_W(CW_A)) bus_a ();
  mm_if #(.W(W), .CNT_W(CW_B)) bus_b ();

  assign bus_b.src       = bus_a.src;
  assign bus_b.copies    = bus_a.copies;
  assign bus_b.start     = bus_a.start;
  assign bus_b.err_ready = bus_a.err_ready;

  mirror_monitor #(.W(W), .SETTLE(SETTLE), .CNT_W(CW_A)) u_dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  mirror_monitor #(.W(W), .SETTLE(SETTLE), .CNT_W(CW_B)) u_dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unknown snapshot fails everything; otherwise a copy fails unless it is exactly the snapshot.
  function automatic logic [W-1:0] model_mask(input logic s, input logic [W-1:0] c);
    logic [W-1:0] m;
    if (!(s === 1'b0 || s === 1'b1)) return '1;
    for (int i = 0; i < int'(W); i++) m[i] = (c[i] !== s);
    return m;
  endfunction

  function automatic int unsigned sat(input int unsigned n, input int unsigned w);
    int unsigned mx = (32'd1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic logic [W-1:0] rand_copies(input logic s);
    logic [W-1:0] c;
    for (int i = 0; i < int'(W); i++) begin
      case ($urandom_range(0, 15))
        12:      c[i] = 1'b0;
        13:      c[i] = 1'b1;
        14:      c[i] = 1'bx;
        15:      c[i] = 1'bz;
        default: c[i] = s;
      endcase
    end
    return c;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      32'(bus_a.busy),      32'(0));
    check({tag, "_err_valid"}, 32'(bus_a.err_valid), 32'(0));
    check({tag, "_err_mask"},  32'(bus_a.err_mask),  32'(0));
    check({tag, "_err_cnt_a"}, 32'(bus_a.err_cnt),   32'(0));
    check({tag, "_err_cnt_b"}, 32'(bus_b.err_cnt),   32'(0));
    check({tag, "_done"},      32'(bus_a.done),      32'(0));
    check({tag, "_state"},     32'(u_dut_a.state_q), 32'(IDLE));
  endtask

  // Monitor: compares whatever the checkers present against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0) begin
      if (bus_a.err_valid === 1'b1) begin
        if (sb_q.size() == 0 || sb_q[0].mask == '0) begin
          check("unexpected_err_valid", 32'(bus_a.err_valid), 32'(0));
        end else begin
          if (!seen_valid) check("report_latency", cyc, sb_q[0].start_cyc + SETTLE + 1);
          seen_valid = 1'b1;
          check("err_mask_a", 32'(bus_a.err_mask), 32'(sb_q[0].mask));
          check("err_mask_b", 32'(bus_b.err_mask), 32'(sb_q[0].mask));
          check("busy_in_report", 32'(bus_a.busy), 32'(1));
        end
      end
      if (bus_a.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 32'(bus_a.done), 32'(0));
        end else begin
          e = sb_q.pop_front();
          if (e.mask == '0) check("pass_latency", cyc, e.start_cyc + SETTLE + 1);
          else              check("report_seen", 32'(seen_valid), 32'(1));
          seen_valid = 1'b0;
          check("done_b",          32'(bus_b.done),      32'(1));
          check("err_cnt_a",       32'(bus_a.err_cnt),   sat(e.cnt, CW_A));
          check("err_cnt_b",       32'(bus_b.err_cnt),   sat(e.cnt, CW_B));
          check("busy_at_done",    32'(bus_a.busy),      32'(0));
          check("valid_at_done",   32'(bus_a.err_valid), 32'(0));
          check("mask_at_done",    32'(bus_a.err_mask),  32'(0));
        end
      end
    end
  end

  // One check: src/copies are scrambled outside the snapshot and compare edges.
  task automatic issue(input logic s, input logic [W-1:0] c, output bit fail);
    exp_t e;
    @(negedge clk);
    bus_a.src    = s;
    bus_a.copies = W'($urandom);
    bus_a.start  = 1'b1;
    e.mask = model_mask(s, c);
    @(negedge clk);
    bus_a.start = 1'b0;
    e.start_cyc = cyc;
    if (e.mask != '0) n_reports++;
    e.cnt = n_reports;
    sb_q.push_back(e);
    bus_a.src    = 1'($urandom);
    bus_a.copies = W'($urandom);
    repeat (SETTLE) @(negedge clk);
    bus_a.copies = c;
    @(negedge clk);
    bus_a.copies = W'($urandom);
    fail = (e.mask != '0);
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 64 && sb_q.size() != 0; k++) @(negedge clk);
    if (sb_q.size() != 0) begin
      check("txn_timeout", 32'(sb_q.size()), 32'(0));
      sb_q.delete();
    end
  endtask

  task automatic complete(input bit fail, input int unsigned delay);
    if (fail) begin
      repeat (delay) @(negedge clk);
      bus_a.err_ready = 1'b1;
    end
    wait_empty();
    bus_a.err_ready = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit           fail;
    logic [W-1:0] c;
    logic         s;
    int unsigned  s0;

    bus_a.src = 1'b0; bus_a.copies = '0; bus_a.start = 1'b0; bus_a.err_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("por");
    rst = 1'b0;

    // All copies match a 1 source.
    issue(1'b1, 14'h3FFF, fail);
    complete(fail, 0);

    // Bit 0 unknown: reported, held with ready low, then accepted.
    c = 14'h3FFE;
    c[0] = 1'bx;
    issue(1'b1, c, fail);
    complete(fail, 5);

    // Unknown source snapshot.
    issue(1'bx, {W{1'bx}}, fail);
    complete(fail, 2);

    // start held high: only accepted once each check has finished.
    @(negedge clk);
    bus_a.src = 1'b1; bus_a.copies = '1; bus_a.start = 1'b1;
    s0 = cyc + 1;
    for (int k = 0; k * (SETTLE + 2) < 20; k++) begin
      sb_q.push_back('{mask: '0, start_cyc: s0 + k * (SETTLE + 2), cnt: n_reports});
    end
    repeat (20) @(negedge clk);
    bus_a.start = 1'b0;
    wait_empty();

    // Async reset while a report is pending.
    c = 14'h3FFF;
    c[3] = 1'b0;
    issue(1'b1, c, fail);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_idle_outputs("mid_report_rst");
    sb_q.delete();
    n_reports  = 0;
    seen_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Five reports back to back: 2-bit counter saturates.
    bus_a.err_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus_a.err_ready = 1'b1;
      issue(1'b0, 14'h0100, fail);
      complete(fail, 0);
    end

    // Random mix of sources, 4-state copies and ready timing.
    for (int k = 0; k < 40; k++) begin
      s = ($urandom_range(0, 9) == 0) ? 1'bx : 1'($urandom);
      bus_a.err_ready = 1'($urandom);
      issue(s, rand_copies(s), fail);
      complete(fail, $urandom_range(0, 4));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
